vga_frame_checker: RTL and testbench
====================================

// Module: vga_frame_checker
// PURPOSE
//  Synthesizable, parametrised self-checker for a raster pixel stream: compares every pixel inside a
//  configurable view window against an expected-pixel stream and reports per-channel mismatch counts,
//  the first failing coordinate and a halt on excess errors. It sits beside VGA_unit (taps its pixel
//  strobe, X/Y position and RGB). It adds a CRC-32 signature mode for on-board golden-frame checks.
// PARAMETERS
//  NUM_CH       3       colour channels per pixel
//  CH_W         8       bits per channel
//  VIEW_LEFT    160     first in-window column (inclusive)
//  VIEW_TOP     120     first in-window row (inclusive)
//  VIEW_W       320     window width in pixels
//  VIEW_H       240     window height in pixels
//  MAX_MISM     999999  halt when total mismatch count exceeds this value
//  CNT_W        20      width of every counter (must hold MAX_MISM+NUM_CH)
// PORTS
//  Clock_50       in   1             system clock, all logic on rising edge
//  Resetn         in   1             asynchronous, active-low reset
//  Enable         in   1             arm checker; low forces IDLE
//  Sig_mode       in   1             0 = compare, 1 = CRC-32 signature; sampled on IDLE->WAIT_FRAME
//  Frame_start    in   1             one-cycle pulse at frame start (negedge Vsync)
//  Pix_valid      in   1             pixel strobe (every other cycle in 640x480 mode)
//  Pix_x, Pix_y   in   10 each       position of the current pixel
//  Pix_data       in   NUM_CH*CH_W   observed pixel; channel 0 is in the MSBs (R,G,B order)
//  Exp_valid      in   1             expected pixel available
//  Exp_data       in   NUM_CH*CH_W   expected pixel, same packing as Pix_data
//  Exp_ready      out  1             expected pixel consumed this cycle
//  State_o        out  3             FSM state (encoding defined in package)
//  Ch_mism        out  NUM_CH*CNT_W  per-channel mismatch counters, saturating
//  Total_mism     out  CNT_W         sum of the channel mismatches, saturating
//  Underrun_cnt   out  CNT_W         in-window pixels that arrived with Exp_valid low
//  First_err_vld  out  1             sticky; First_err_x and First_err_y hold the first mismatch
//  First_err_x/y  out  10 each       coordinate of the first mismatch
//  Signature      out  32            CRC-32 over in-window pixels (signature mode)
//  Done           out  1             frame finished (level, held in DONE)
//  Halted         out  1             mismatch limit exceeded (level, held in HALT)
// BEHAVIOUR
//  Reset: state IDLE; all counters, Signature, First_err_* and flags are 0; Exp_ready is 0.
//  in_win = Pix_valid & Pix_x in [VIEW_LEFT, VIEW_LEFT+VIEW_W) & Pix_y in [VIEW_TOP, VIEW_TOP+VIEW_H).
//  FSM:
//   IDLE       -> WAIT_FRAME when Enable=1. On this transition, clear counters, CRC (to 32'hFFFFFFFF)
//                 and flags, and latch Sig_mode.
//   WAIT_FRAME -> CHECK on Frame_start. Pixels in this state are ignored.
//   CHECK      -> DONE one cycle after the last in-window pixel (x=VIEW_LEFT+VIEW_W-1,
//                 y=VIEW_TOP+VIEW_H-1) is processed.
//              -> HALT when registered Total_mism > MAX_MISM.
//              -> DONE early on a Frame_start before the window completes (short frame);
//                 Underrun_cnt is not changed.
//   DONE, HALT hold until Enable=0. Any state goes to IDLE the cycle after Enable=0.
//   Counters hold their values in IDLE until the next arm.
//  Compare mode: Exp_ready = (state==CHECK) & in_win & Exp_valid. This is combinational, with no
//   registered dependency on Exp_ready, so one pixel is popped per strobe.
//   - If in_win & !Exp_valid: Underrun_cnt+1; no compare; no pop.
//   - On a pop: each channel i mismatch increments Ch_mism[i]. Total_mism adds the popcount (0..NUM_CH).
//   - Results are visible 1 cycle after the strobe. All adds saturate at 2^CNT_W-1.
//   - First mismatch in the frame latches Pix_x and Pix_y and sets First_err_vld. Later mismatches
//     leave them unchanged.
//  Signature mode: Exp_ready is held at 0. CRC-32 (poly 04C11DB7, reflected in/out) over Pix_data
//   bytes MSB-byte first, one pixel per in-window strobe. Signature = ~crc, updated 1 cycle after
//   the strobe. Compare counters stay at 0.
//  Simultaneous events: Enable=0 has priority over all. HALT has priority over DONE in the same cycle.
//   A Frame_start in the same cycle as an in-window strobe processes the pixel first.
//  Asynchronous reset mid-frame returns to IDLE at once; the bench re-arms.
// STRUCTURE
//  vga_check_pkg: checker_state_t enum (IDLE, WAIT_FRAME, CHECK, DONE, HALT) and CRC32_POLY.
//  Sub-module pixel_crc32: combinational parallel CRC update over NUM_CH*CH_W bits per pixel.
//  Counters and FSM stay in the top module. Per-channel compare uses a generate loop.
// TESTING
//  1 Defaults, expected stream = observed, Enable and one frame -> Done=1, Total_mism=0,
//    Underrun_cnt=0, 76800 pops.
//  2 Corrupt G of pixel (200,130) by 8'h01 -> Ch_mism[1]=1, Total_mism=1, First_err=(200,130).
//  3 MAX_MISM=5, all channels wrong from pixel (160,120) -> HALT after the 2nd pixel (Total_mism=6),
//    Halted=1, Exp_ready=0.
//  4 Exp_valid=0 for 10 in-window strobes -> Underrun_cnt=10, Total_mism=0, window still completes.
//  5 Sig_mode=1, all pixels 24'h000000 -> Signature equals the reference CRC-32 of 230400 zero bytes;
//    Exp_ready is never 1.
//  6 Drop Resetn mid-CHECK, re-arm with Enable, full frame -> counters restart from 0 and match scenario 1.

Source files
------------

// File: rtl/vga_check_pkg.sv
// Shared types and constants for the raster frame checker.
package vga_check_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FRAME = 3'd1,
        CHECK      = 3'd2,
        DONE       = 3'd3,
        HALT       = 3'd4
    } checker_state_t;

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

    // Reflected-output view of a CRC register kept in normal (MSB-first) order.
    function automatic logic [31:0] bit_rev32(input logic [31:0] d);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = d[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_frame_checker_if.sv
// Pixel tap, expected-pixel stream and result bundle of the frame checker.
interface vga_frame_checker_if #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned CH_W   = 8,
    parameter int unsigned CNT_W  = 20
);
    logic                      Enable;
    logic                      Sig_mode;
    logic                      Frame_start;
    logic                      Pix_valid;
    logic [9:0]                Pix_x;
    logic [9:0]                Pix_y;
    logic [NUM_CH*CH_W-1:0]    Pix_data;
    logic                      Exp_valid;
    logic [NUM_CH*CH_W-1:0]    Exp_data;
    logic                      Exp_ready;
    logic [2:0]                State_o;
    logic [NUM_CH*CNT_W-1:0]   Ch_mism;
    logic [CNT_W-1:0]          Total_mism;
    logic [CNT_W-1:0]          Underrun_cnt;
    logic                      First_err_vld;
    logic [9:0]                First_err_x;
    logic [9:0]                First_err_y;
    logic [31:0]               Signature;
    logic                      Done;
    logic                      Halted;

    modport master (
        output Enable, Sig_mode, Frame_start, Pix_valid, Pix_x, Pix_y, Pix_data,
               Exp_valid, Exp_data,
        input  Exp_ready, State_o, Ch_mism, Total_mism, Underrun_cnt, First_err_vld,
               First_err_x, First_err_y, Signature, Done, Halted
    );

    modport slave (
        input  Enable, Sig_mode, Frame_start, Pix_valid, Pix_x, Pix_y, Pix_data,
               Exp_valid, Exp_data,
        output Exp_ready, State_o, Ch_mism, Total_mism, Underrun_cnt, First_err_vld,
               First_err_x, First_err_y, Signature, Done, Halted
    );
endinterface

// File: rtl/pixel_crc32.sv
// Combinational CRC-32 update over one pixel: bytes MSB-first, bits of each byte LSB-first
// (reflected input), register kept in normal bit order.
module pixel_crc32
    import vga_check_pkg::*;
#(
    parameter int unsigned DATA_W = 24
) (
    input  logic [31:0]       i_crc,
    input  logic [DATA_W-1:0] i_data,
    output logic [31:0]       o_crc
);
    localparam int unsigned NBYTES = DATA_W / 8;

    logic [7:0] w_byte;
    logic       w_fb;

    always_comb begin
        o_crc  = i_crc;
        w_byte = '0;
        w_fb   = 1'b0;
        for (int k = NBYTES - 1; k >= 0; k--) begin
            w_byte = 8'(i_data >> (k * 8));
            for (int j = 0; j < 8; j++) begin
                w_fb   = o_crc[31] ^ w_byte[0];
                o_crc  = {o_crc[30:0], 1'b0} ^ (w_fb ? CRC32_POLY : 32'h0);
                w_byte = w_byte >> 1;
            end
        end
    end

endmodule

// File: rtl/vga_frame_checker.sv
// In-window pixel self-checker: per-channel compare against an expected stream, or CRC-32
// signature of the window, with first-error capture and a mismatch-limit halt.
module vga_frame_checker
    import vga_check_pkg::*;
#(
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned CH_W      = 8,
    parameter int unsigned VIEW_LEFT = 160,
    parameter int unsigned VIEW_TOP  = 120,
    parameter int unsigned VIEW_W    = 320,
    parameter int unsigned VIEW_H    = 240,
    parameter int unsigned MAX_MISM  = 999999,
    parameter int unsigned CNT_W     = 20
) (
    input  logic               Clock_50,
    input  logic               Resetn,
    vga_frame_checker_if.slave bus
);
    localparam int unsigned    PIX_W    = NUM_CH * CH_W;
    localparam int unsigned    PC_W     = $clog2(NUM_CH + 1);
    localparam logic [9:0]     X_LO     = 10'(VIEW_LEFT);
    localparam logic [9:0]     X_HI     = 10'(VIEW_LEFT + VIEW_W - 1);
    localparam logic [9:0]     Y_LO     = 10'(VIEW_TOP);
    localparam logic [9:0]     Y_HI     = 10'(VIEW_TOP + VIEW_H - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MISM_LIM = CNT_W'(MAX_MISM);

    checker_state_t    r_state, w_state_next;
    logic              r_sig_mode, r_done, r_halted;
    logic              r_first_vld;
    logic [9:0]        r_first_x, r_first_y;
    logic [CNT_W-1:0]  r_total, r_underrun;
    logic [31:0]       r_crc, r_signature, w_crc_next;

    logic              w_in_win, w_last_pix, w_arm, w_strobe;
    logic              w_pop, w_underrun, w_sig_upd;
    logic [NUM_CH-1:0] w_ch_neq;
    logic [PC_W-1:0]   w_popcnt;
    logic [CNT_W:0]    w_total_sum;

    assign w_in_win   = bus.Pix_valid
                      & (bus.Pix_x >= X_LO) & (bus.Pix_x <= X_HI)
                      & (bus.Pix_y >= Y_LO) & (bus.Pix_y <= Y_HI);
    assign w_last_pix = w_in_win & (bus.Pix_x == X_HI) & (bus.Pix_y == Y_HI);
    assign w_arm      = (r_state == IDLE) & bus.Enable;
    assign w_strobe   = (r_state == CHECK) & w_in_win;
    assign w_pop      = w_strobe & ~r_sig_mode & bus.Exp_valid;
    assign w_underrun = w_strobe & ~r_sig_mode & ~bus.Exp_valid;
    assign w_sig_upd  = w_strobe & r_sig_mode;

    // Pop is combinational so the expected stream advances on the same strobe it is compared.
    assign bus.Exp_ready = w_pop;

    // Per-channel compare and saturating mismatch counter.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;

        assign w_ch_neq[g] = w_pop & (bus.Pix_data[PIX_W-1-g*CH_W -: CH_W]
                                      != bus.Exp_data[PIX_W-1-g*CH_W -: CH_W]);

        always_ff @(posedge Clock_50 or negedge Resetn) begin
            if (!Resetn) begin
                r_cnt <= '0;
            end else if (w_arm) begin
                r_cnt <= '0;
            end else if (w_ch_neq[g] && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign bus.Ch_mism[g*CNT_W +: CNT_W] = r_cnt;
    end

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_popcnt = w_popcnt + PC_W'(w_ch_neq[i]);
        end
    end

    assign w_total_sum = {1'b0, r_total} + (CNT_W+1)'(w_popcnt);

    pixel_crc32 #(.DATA_W(PIX_W)) u_crc (
        .i_crc  (r_crc),
        .i_data (bus.Pix_data),
        .o_crc  (w_crc_next)
    );

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_done   <= (w_state_next == DONE);
            r_halted <= (w_state_next == HALT);
        end
    end

    // Halt outranks window completion; Enable low outranks everything.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:       if (bus.Enable) w_state_next = WAIT_FRAME;
            WAIT_FRAME: if (bus.Frame_start) w_state_next = CHECK;
            CHECK: begin
                if (r_total > MISM_LIM) begin
                    w_state_next = HALT;
                end else if (w_last_pix || bus.Frame_start) begin
                    w_state_next = DONE;
                end
            end
            DONE:       w_state_next = DONE;
            HALT:       w_state_next = HALT;
            default:    w_state_next = IDLE;
        endcase
        if (!bus.Enable) begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_sig_mode  <= 1'b0;
            r_total     <= '0;
            r_underrun  <= '0;
            r_first_vld <= 1'b0;
            r_first_x   <= '0;
            r_first_y   <= '0;
            r_crc       <= CRC32_INIT;
            r_signature <= '0;
        end else if (w_arm) begin
            r_sig_mode  <= bus.Sig_mode;
            r_total     <= '0;
            r_underrun  <= '0;
            r_first_vld <= 1'b0;
            r_first_x   <= '0;
            r_first_y   <= '0;
            r_crc       <= CRC32_INIT;
            r_signature <= '0;
        end else begin
            if (w_pop) begin
                r_total <= w_total_sum[CNT_W] ? CNT_MAX : w_total_sum[CNT_W-1:0];
            end
            if (w_underrun && (r_underrun != CNT_MAX)) begin
                r_underrun <= r_underrun + CNT_W'(1);
            end
            if ((|w_ch_neq) && !r_first_vld) begin
                r_first_vld <= 1'b1;
                r_first_x   <= bus.Pix_x;
                r_first_y   <= bus.Pix_y;
            end
            if (w_sig_upd) begin
                r_crc       <= w_crc_next;
                r_signature <= ~bit_rev32(w_crc_next);
            end
        end
    end

    assign bus.State_o       = r_state;
    assign bus.Total_mism    = r_total;
    assign bus.Underrun_cnt  = r_underrun;
    assign bus.First_err_vld = r_first_vld;
    assign bus.First_err_x   = r_first_x;
    assign bus.First_err_y   = r_first_y;
    assign bus.Signature     = r_signature;
    assign bus.Done          = r_done;
    assign bus.Halted        = r_halted;

endmodule

// File: tb/tb_vga_frame_checker.sv
// Directed bench for vga_frame_checker on a reduced 16x12 raster with an 8x6 view window.
`timescale 1ns/1ps
module tb_vga_frame_checker;
    import vga_check_pkg::*;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CH_W   = 8;
    localparam int unsigned VL     = 4;
    localparam int unsigned VT     = 3;
    localparam int unsigned VW     = 8;
    localparam int unsigned VH     = 6;
    localparam int unsigned MAXM   = 5;
    localparam int unsigned CNT_W  = 20;
    localparam int unsigned H_TOT  = 16;
    localparam int unsigned V_TOT  = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_frame_checker_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W)) bus ();

    vga_frame_checker #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .VIEW_LEFT(VL), .VIEW_TOP(VT),
        .VIEW_W(VW), .VIEW_H(VH), .MAX_MISM(MAXM), .CNT_W(CNT_W)
    ) dut (
        .Clock_50 (clk),
        .Resetn   (rst_n),
        .bus      (bus)
    );

    int checks   = 0;
    int failures = 0;
    int pop_cnt  = 0;
    int pops0    = 0;

    always @(negedge clk) begin
        if (bus.Exp_ready === 1'b1) pop_cnt <= pop_cnt + 1;
    end

    function automatic logic [23:0] pix_of(input int x, input int y);
        return {8'(x) ^ 8'hA5, 8'(y) ^ 8'h3C, 8'(x + y)};
    endfunction

    function automatic bit in_win(input int x, input int y);
        return (x >= int'(VL)) && (x < int'(VL + VW)) && (y >= int'(VT)) && (y < int'(VT + VH));
    endfunction

    // Reference CRC-32 in the classic reflected (0xEDB88320, right-shifting) form.
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] frame_crc(input bit zero_data);
        logic [31:0] c;
        logic [23:0] p;
        c = 32'hFFFFFFFF;
        for (int y = int'(VT); y < int'(VT + VH); y++) begin
            for (int x = int'(VL); x < int'(VL + VW); x++) begin
                p = zero_data ? 24'h0 : pix_of(x, y);
                for (int b = 2; b >= 0; b--) c = crc_byte(c, 8'(p >> (8 * b)));
            end
        end
        return ~c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic arm(input logic sig);
        bus.Enable = 1'b0;
        tick();
        tick();
        bus.Sig_mode = sig;
        bus.Enable   = 1'b1;
        tick();
        pops0 = pop_cnt;
    endtask

    task automatic pulse_frame_start();
        bus.Frame_start = 1'b1;
        tick();
        bus.Frame_start = 1'b0;
    endtask

    // One raster frame, pixel strobe every other cycle.
    task automatic run_frame(input int rows, input int bad_x, input int bad_y,
                             input logic [23:0] bad_mask, input bit all_bad,
                             input int n_under, input bit zero_data);
        int under_left;
        logic [23:0] p;
        under_left = n_under;
        pulse_frame_start();
        for (int y = 0; y < rows; y++) begin
            for (int x = 0; x < int'(H_TOT); x++) begin
                p = zero_data ? 24'h0 : pix_of(x, y);
                bus.Pix_x     = 10'(x);
                bus.Pix_y     = 10'(y);
                bus.Pix_data  = p;
                bus.Pix_valid = 1'b1;
                bus.Exp_data  = all_bad ? ~p : (((x == bad_x) && (y == bad_y)) ? (p ^ bad_mask) : p);
                bus.Exp_valid = 1'b1;
                if (in_win(x, y) && (under_left > 0)) begin
                    bus.Exp_valid = 1'b0;
                    under_left--;
                end
                tick();
                bus.Pix_valid = 1'b0;
                bus.Exp_valid = 1'b1;
                tick();
            end
        end
    endtask

    task automatic check_clean_frame(input string tag);
        @(negedge clk);
        chk({tag, "_state"},    32'(bus.State_o), 32'(DONE));
        chk({tag, "_done"},     32'(bus.Done), 32'd1);
        chk({tag, "_total"},    32'(bus.Total_mism), 32'd0);
        chk({tag, "_underrun"}, 32'(bus.Underrun_cnt), 32'd0);
        chk({tag, "_ferr"},     32'(bus.First_err_vld), 32'd0);
        chk({tag, "_pops"},     32'(pop_cnt - pops0), 32'(VW * VH));
    endtask

    initial begin
        bus.Enable      = 1'b0;
        bus.Sig_mode    = 1'b0;
        bus.Frame_start = 1'b0;
        bus.Pix_valid   = 1'b0;
        bus.Pix_x       = '0;
        bus.Pix_y       = '0;
        bus.Pix_data    = '0;
        bus.Exp_valid   = 1'b0;
        bus.Exp_data    = '0;

        // Reset state
        #23;
        chk("rst_state",  32'(bus.State_o), 32'(IDLE));
        chk("rst_total",  32'(bus.Total_mism), 32'd0);
        chk("rst_sig",    bus.Signature, 32'd0);
        chk("rst_ready",  32'(bus.Exp_ready), 32'd0);
        chk("rst_done",   32'(bus.Done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: clean frame
        arm(1'b0);
        chk("s1_wait", 32'(bus.State_o), 32'(WAIT_FRAME));
        run_frame(V_TOT, -1, -1, 24'h0, 1'b0, 0, 1'b0);
        check_clean_frame("s1");

        // 2: single green-channel error
        arm(1'b0);
        run_frame(V_TOT, 9, 5, 24'h000100, 1'b0, 0, 1'b0);
        @(negedge clk);
        chk("s2_ch0",   32'(bus.Ch_mism[0*CNT_W +: CNT_W]), 32'd0);
        chk("s2_ch1",   32'(bus.Ch_mism[1*CNT_W +: CNT_W]), 32'd1);
        chk("s2_ch2",   32'(bus.Ch_mism[2*CNT_W +: CNT_W]), 32'd0);
        chk("s2_total", 32'(bus.Total_mism), 32'd1);
        chk("s2_fvld",  32'(bus.First_err_vld), 32'd1);
        chk("s2_fx",    32'(bus.First_err_x), 32'd9);
        chk("s2_fy",    32'(bus.First_err_y), 32'd5);
        chk("s2_done",  32'(bus.Done), 32'd1);

        // Counters hold in IDLE
        bus.Enable = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("idle_state", 32'(bus.State_o), 32'(IDLE));
        chk("idle_total", 32'(bus.Total_mism), 32'd1);
        chk("idle_done",  32'(bus.Done), 32'd0);

        // 3: every channel wrong, halt after second in-window pixel
        arm(1'b0);
        run_frame(V_TOT, -1, -1, 24'h0, 1'b1, 0, 1'b0);
        @(negedge clk);
        chk("s3_state",  32'(bus.State_o), 32'(HALT));
        chk("s3_halted", 32'(bus.Halted), 32'd1);
        chk("s3_done",   32'(bus.Done), 32'd0);
        chk("s3_total",  32'(bus.Total_mism), 32'd6);
        chk("s3_ch0",    32'(bus.Ch_mism[0*CNT_W +: CNT_W]), 32'd2);
        chk("s3_fx",     32'(bus.First_err_x), 32'(VL));
        chk("s3_fy",     32'(bus.First_err_y), 32'(VT));
        chk("s3_pops",   32'(pop_cnt - pops0), 32'd2);
        bus.Pix_x = 10'(VL + 1);
        bus.Pix_y = 10'(VT + 1);
        bus.Pix_valid = 1'b1;
        bus.Exp_valid = 1'b1;
        @(negedge clk);
        chk("s3_ready", 32'(bus.Exp_ready), 32'd0);
        tick();
        bus.Pix_valid = 1'b0;

        // 4: underrun on the first 10 in-window strobes
        arm(1'b0);
        run_frame(V_TOT, -1, -1, 24'h0, 1'b0, 10, 1'b0);
        @(negedge clk);
        chk("s4_underrun", 32'(bus.Underrun_cnt), 32'd10);
        chk("s4_total",    32'(bus.Total_mism), 32'd0);
        chk("s4_done",     32'(bus.Done), 32'd1);
        chk("s4_pops",     32'(pop_cnt - pops0), 32'(VW * VH - 10));

        // Short frame: Frame_start before window completes
        arm(1'b0);
        run_frame(5, -1, -1, 24'h0, 1'b0, 3, 1'b0);
        @(negedge clk);
        chk("short_check", 32'(bus.State_o), 32'(CHECK));
        pulse_frame_start();
        @(negedge clk);
        chk("short_done",     32'(bus.Done), 32'd1);
        chk("short_underrun", 32'(bus.Underrun_cnt), 32'd3);
        chk("short_pops",     32'(pop_cnt - pops0), 32'd13);

        // 5: signature over all-zero window
        arm(1'b1);
        run_frame(V_TOT, -1, -1, 24'h0, 1'b0, 0, 1'b1);
        @(negedge clk);
        chk("s5_sig",   bus.Signature, frame_crc(1'b1));
        chk("s5_pops",  32'(pop_cnt - pops0), 32'd0);
        chk("s5_total", 32'(bus.Total_mism), 32'd0);
        chk("s5_done",  32'(bus.Done), 32'd1);

        // 5b: signature over a patterned window (checks byte order)
        arm(1'b1);
        run_frame(V_TOT, -1, -1, 24'h0, 1'b0, 0, 1'b0);
        @(negedge clk);
        chk("s5b_sig", bus.Signature, frame_crc(1'b0));

        // 6: async reset mid-CHECK, then a clean frame
        arm(1'b0);
        pulse_frame_start();
        for (int x = int'(VL); x < int'(VL) + 3; x++) begin
            bus.Pix_x     = 10'(x);
            bus.Pix_y     = 10'(VT);
            bus.Pix_data  = pix_of(x, int'(VT));
            bus.Exp_data  = pix_of(x, int'(VT)) ^ 24'h010000;
            bus.Exp_valid = 1'b1;
            bus.Pix_valid = 1'b1;
            tick();
            bus.Pix_valid = 1'b0;
            tick();
        end
        @(negedge clk);
        chk("s6_pre_total", 32'(bus.Total_mism), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_rst_state", 32'(bus.State_o), 32'(IDLE));
        chk("s6_rst_total", 32'(bus.Total_mism), 32'd0);
        chk("s6_rst_ferr",  32'(bus.First_err_vld), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        arm(1'b0);
        run_frame(V_TOT, -1, -1, 24'h0, 1'b0, 0, 1'b0);
        check_clean_frame("s6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
